bcd_mult_node: RTL and testbench

BCD_MULT_NODE -- requirements
Module: bcd_mult_node

---
 rtl/bcd_mult_pkg.sv | 41 ++++
 rtl/bcd_dabble_seq.sv | 54 +++++
 rtl/bcd_mult_node.sv | 151 +++++++++++++++
 tb/tb_bcd_mult_node.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_mult_pkg.sv
// ============================================================================
// Module   : bcd_mult_pkg
// Shared state encoding, width helpers and constants for bcd_mult_node.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bcd_mult_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CONV  = 3'd1,
    S_MULT  = 3'd2,
    S_BCD   = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  localparam int TEN = 10;

  function automatic int calc_bw(input int digits);
    return 4 * digits;
  endfunction

  function automatic int calc_ow(input int digits, input int frac_digits);
    return 4 * (2 * digits - frac_digits);
  endfunction

  function automatic int calc_latency(input int digits);
    return digits + 3 * calc_bw(digits) + 1;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_dabble_seq.sv
// ============================================================================
// Module   : bcd_dabble_seq
// Bit-serial double-dabble: one add-3/shift step per cycle, IW cycles per start.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_dabble_seq #(
  parameter  int IW   = 32,
  parameter  int NDIG = 8,
  parameter  int DROP = 0,
  localparam int CNTW = $clog2(IW + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [IW-1:0]             bin,
  output logic                      done,
  output logic [4*(NDIG-DROP)-1:0]  bcd
);

  logic [IW-1:0]     bin_r;
  logic [4*NDIG-1:0] bcd_r;
  logic [4*NDIG-1:0] w_adj;
  logic [CNTW-1:0]   cnt_r;

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    assign w_adj[4*g +: 4] = (bcd_r[4*g +: 4] >= 4'd5) ? bcd_r[4*g +: 4] + 4'd3
                                                        : bcd_r[4*g +: 4];
  end

  // start performs the first shift itself (nothing to adjust yet), so a run is exactly IW cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_r <= '0;
      bcd_r <= '0;
      cnt_r <= '0;
    end else if (start) begin
      bin_r <= bin << 1;
      bcd_r <= (4*NDIG)'(bin[IW-1]);
      cnt_r <= CNTW'(IW - 1);
    end else if (cnt_r != '0) begin
      bin_r <= bin_r << 1;
      bcd_r <= (w_adj << 1) | (4*NDIG)'(bin_r[IW-1]);
      cnt_r <= cnt_r - 1'b1;
    end
  end

  assign done = (cnt_r == CNTW'(1));
  assign bcd  = bcd_r[4*NDIG-1:4*DROP];

endmodule

`default_nettype wire

// File: rtl/bcd_mult_node.sv
// ============================================================================
// Module   : bcd_mult_node
// Sequential BCD x BCD multiplier between show-ahead FIFOs; macro BCD_MULT_ROUND_EN rounds.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_mult_node
  import bcd_mult_pkg::*;
#(
  parameter  int DIGITS      = 4,
  parameter  int FRAC_DIGITS = 1,
  localparam int BW          = calc_bw(DIGITS),
  localparam int OW          = calc_ow(DIGITS, FRAC_DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [BW-1:0] entry_1,
  input  logic [BW-1:0] entry_2,
  input  logic          in_empty_1,
  input  logic          in_empty_2,
  output logic          rd,
  input  logic          out_full,
  output logic          wr,
  output logic [OW-1:0] output_1,
  output logic          busy,
  output logic          err
);

  localparam int PW = 2 * BW;
  localparam int CW = $clog2(BW) + 1;

`ifdef BCD_MULT_ROUND_EN
  localparam logic [PW-1:0] ROUND_ADD = (FRAC_DIGITS > 0) ? PW'(64'd5 * pow10(FRAC_DIGITS - 1)) : '0;
`else
  localparam logic [PW-1:0] ROUND_ADD = '0;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] a_bcd, b_bcd;
  logic [PW-1:0] acc_a;
  logic [BW-1:0] acc_b;
  logic [PW-1:0] prod;

  logic [3:0]    w_nib_a, w_nib_b, w_dig_a, w_dig_b;
  logic [PW-1:0] w_a_next;
  logic [BW-1:0] w_b_next;
  logic [PW-1:0] w_prod_add;
  logic          w_dab_start, w_dab_done;

  assign w_nib_a    = a_bcd[BW-1 -: 4];
  assign w_nib_b    = b_bcd[BW-1 -: 4];
  assign w_dig_a    = (w_nib_a > 4'd9) ? 4'd9 : w_nib_a;
  assign w_dig_b    = (w_nib_b > 4'd9) ? 4'd9 : w_nib_b;
  assign w_a_next   = acc_a * PW'(TEN) + PW'(w_dig_a);
  assign w_b_next   = acc_b * BW'(TEN) + BW'(w_dig_b);
  assign w_prod_add = prod + (acc_b[0] ? acc_a : '0);
  assign w_dab_start = (state == S_BCD) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rd    <= 1'b0;
      wr    <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
      a_bcd <= '0;
      b_bcd <= '0;
      acc_a <= '0;
      acc_b <= '0;
      prod  <= '0;
    end else begin
      rd <= 1'b0;
      wr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!in_empty_1 && !in_empty_2) begin
            rd    <= 1'b1;
            busy  <= 1'b1;
            a_bcd <= entry_1;
            b_bcd <= entry_2;
            acc_a <= '0;
            acc_b <= '0;
            prod  <= '0;
            cnt   <= '0;
            state <= S_CONV;
          end
        end
        // Most significant digit first; operands shift left so the top nibble is always current
        S_CONV: begin
          acc_a <= w_a_next;
          acc_b <= w_b_next;
          a_bcd <= a_bcd << 4;
          b_bcd <= b_bcd << 4;
          err   <= err | (w_nib_a > 4'd9) | (w_nib_b > 4'd9);
          if (cnt == CW'(DIGITS - 1)) begin
            cnt   <= '0;
            state <= S_MULT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_MULT: begin
          acc_a <= acc_a << 1;
          acc_b <= acc_b >> 1;
          if (cnt == CW'(BW - 1)) begin
            prod  <= w_prod_add + ROUND_ADD;
            cnt   <= '0;
            state <= S_BCD;
          end else begin
            prod <= w_prod_add;
            cnt  <= cnt + 1'b1;
          end
        end
        S_BCD: begin
          cnt <= CW'(1);
          if (w_dab_done) state <= S_WRITE;
        end
        S_WRITE: begin
          if (!out_full) begin
            wr    <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  bcd_dabble_seq #(
    .IW   (PW),
    .NDIG (2 * DIGITS),
    .DROP (FRAC_DIGITS)
  ) u_dabble (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_dab_start),
    .bin   (prod),
    .done  (w_dab_done),
    .bcd   (output_1)
  );

endmodule

`default_nettype wire

// File: tb/tb_bcd_mult_node.sv
// ============================================================================
// Module   : tb_bcd_mult_node
// Directed self-checking bench for bcd_mult_node at default parameters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_mult_node;

  localparam int L = 53;

`ifdef BCD_MULT_ROUND_EN
  localparam logic [27:0] EXP_25  = 28'h0000063;
  localparam logic [27:0] EXP_ERR = 28'h0000019;
`else
  localparam logic [27:0] EXP_25  = 28'h0000062;
  localparam logic [27:0] EXP_ERR = 28'h0000018;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] entry_1, entry_2;
  logic        in_empty_1, in_empty_2;
  logic        rd, wr, out_full, busy, err;
  logic [27:0] output_1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_mult_node dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .entry_1    (entry_1),
    .entry_2    (entry_2),
    .in_empty_1 (in_empty_1),
    .in_empty_2 (in_empty_2),
    .rd         (rd),
    .out_full   (out_full),
    .wr         (wr),
    .output_1   (output_1),
    .busy       (busy),
    .err        (err)
  );

  // Presents one operand pair, pops it on rd, and returns at the negedge of the wr cycle.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, output bit got_rd,
                       output bit busy_rd, output int lat, output logic [27:0] res,
                       output bit got_wr);
    @(negedge clk);
    entry_1 = a; entry_2 = b; in_empty_1 = 1'b0; in_empty_2 = 1'b0;
    got_rd = 1'b0;
    for (int i = 0; i < 20 && !got_rd; i++) begin
      @(negedge clk);
      got_rd = rd;
    end
    busy_rd = busy;
    in_empty_1 = 1'b1; in_empty_2 = 1'b1;
    lat = 0; got_wr = 1'b0;
    while (!got_wr && lat < 200) begin
      @(negedge clk);
      lat++;
      got_wr = wr;
    end
    res = output_1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; entry_1 = '0; entry_2 = '0;
    in_empty_1 = 1'b1; in_empty_2 = 1'b1; out_full = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rd !== 1'b0)        begin n_bad++; $display("FAIL reset_rd: got %b want 0", rd); end
    n_cmp++; if (wr !== 1'b0)        begin n_bad++; $display("FAIL reset_wr: got %b want 0", wr); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (err !== 1'b0)       begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (output_1 !== 28'h0) begin n_bad++; $display("FAIL reset_out: got %h want 0", output_1); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (rd !== 1'b0)        begin n_bad++; $display("FAIL idle_rd: got %b want 0", rd); end
  endtask

  task automatic test_basic;
    bit g_rd, b_rd, g_wr; int lat; logic [27:0] res;
    do_op(16'h0025, 16'h0025, g_rd, b_rd, lat, res, g_wr);
    n_cmp++; if (g_rd !== 1'b1)  begin n_bad++; $display("FAIL basic_rd: got %b want 1", g_rd); end
    n_cmp++; if (b_rd !== 1'b1)  begin n_bad++; $display("FAIL basic_busy: got %b want 1", b_rd); end
    n_cmp++; if (lat != L)       begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", lat, L); end
    n_cmp++; if (res !== EXP_25) begin n_bad++; $display("FAIL basic_out: got %h want %h", res, EXP_25); end
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL basic_busy_wr: got %b want 0", busy); end
    @(negedge clk);
    n_cmp++; if (wr !== 1'b0)    begin n_bad++; $display("FAIL basic_wr_pulse: got %b want 0", wr); end
  endtask

  task automatic test_patterns;
    bit g_rd, b_rd, g_wr; int lat; logic [27:0] res;
    do_op(16'h9999, 16'h9999, g_rd, b_rd, lat, res, g_wr);
    n_cmp++; if (res !== 28'h9998000) begin n_bad++; $display("FAIL max_out: got %h want 9998000", res); end
    n_cmp++; if (err !== 1'b0)        begin n_bad++; $display("FAIL max_err: got %b want 0", err); end
    do_op(16'h0000, 16'h1234, g_rd, b_rd, lat, res, g_wr);
    n_cmp++; if (res !== 28'h0000000) begin n_bad++; $display("FAIL zero_out: got %h want 0000000", res); end
    do_op(16'h1234, 16'h5678, g_rd, b_rd, lat, res, g_wr);
    n_cmp++; if (res !== 28'h0700665) begin n_bad++; $display("FAIL mix_out: got %h want 0700665", res); end
    n_cmp++; if (lat != L)            begin n_bad++; $display("FAIL mix_latency: got %0d want %0d", lat, L); end
  endtask

  task automatic test_backpressure;
    int lat; bit unstable, wr_seen; logic [27:0] held;
    out_full = 1'b1;
    @(negedge clk);
    entry_1 = 16'h1234; entry_2 = 16'h5678; in_empty_1 = 1'b0; in_empty_2 = 1'b0;
    lat = 0;
    while (!rd && lat < 20) begin @(negedge clk); lat++; end
    in_empty_1 = 1'b1; in_empty_2 = 1'b1;
    repeat (L - 1) @(negedge clk);
    held = output_1; unstable = 1'b0; wr_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (wr) wr_seen = 1'b1;
      if (output_1 !== held) unstable = 1'b1;
      if (i < 9) @(negedge clk);
    end
    n_cmp++; if (wr_seen !== 1'b0)    begin n_bad++; $display("FAIL full_wr_low: got %b want 0", wr_seen); end
    n_cmp++; if (unstable !== 1'b0)   begin n_bad++; $display("FAIL full_out_stable: got %b want 0", unstable); end
    n_cmp++; if (held !== 28'h0700665) begin n_bad++; $display("FAIL full_out: got %h want 0700665", held); end
    out_full = 1'b0;
    @(negedge clk);
    n_cmp++; if (wr !== 1'b1)         begin n_bad++; $display("FAIL full_wr_release: got %b want 1", wr); end
    @(negedge clk);
    n_cmp++; if (wr !== 1'b0)         begin n_bad++; $display("FAIL full_wr_single: got %b want 0", wr); end
  endtask

  task automatic test_err;
    bit g_rd, b_rd, g_wr; int lat; logic [27:0] res;
    do_op(16'h00A3, 16'h0002, g_rd, b_rd, lat, res, g_wr);
    n_cmp++; if (res !== EXP_ERR) begin n_bad++; $display("FAIL err_out: got %h want %h", res, EXP_ERR); end
    n_cmp++; if (err !== 1'b1)    begin n_bad++; $display("FAIL err_set: got %b want 1", err); end
    do_op(16'h0001, 16'h0001, g_rd, b_rd, lat, res, g_wr);
    n_cmp++; if (err !== 1'b1)    begin n_bad++; $display("FAIL err_sticky: got %b want 1", err); end
    n_cmp++; if (res !== 28'h0)   begin n_bad++; $display("FAIL one_out: got %h want 0000000", res); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (err !== 1'b0)    begin n_bad++; $display("FAIL err_clear: got %b want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid;
    bit g_rd, b_rd, g_wr; int lat, n_wr; logic [27:0] res;
    @(negedge clk);
    entry_1 = 16'h0099; entry_2 = 16'h0099; in_empty_1 = 1'b0; in_empty_2 = 1'b0;
    lat = 0;
    while (!rd && lat < 20) begin @(negedge clk); lat++; end
    in_empty_1 = 1'b1; in_empty_2 = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy_reset: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    n_wr = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (wr) n_wr++;
    end
    n_cmp++; if (n_wr != 0)       begin n_bad++; $display("FAIL mid_no_wr: got %0d want 0", n_wr); end
    do_op(16'h0012, 16'h0011, g_rd, b_rd, lat, res, g_wr);
    n_cmp++; if (res !== 28'h0000013) begin n_bad++; $display("FAIL mid_next_out: got %h want 0000013", res); end
    n_cmp++; if (lat != L)        begin n_bad++; $display("FAIL mid_next_latency: got %0d want %0d", lat, L); end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    entry_1 = 16'h0007; entry_2 = 16'h0003; in_empty_1 = 1'b0; in_empty_2 = 1'b0;
    n = 0;
    while (!rd && n < 20) begin @(negedge clk); n++; end
    entry_1 = 16'h0050; entry_2 = 16'h0040;
    n = 0;
    while (!wr && n < 200) begin @(negedge clk); n++; end
    n_cmp++; if (output_1 !== 28'h0000002) begin n_bad++; $display("FAIL b2b_first_out: got %h want 0000002", output_1); end
    n_cmp++; if (rd !== 1'b0) begin n_bad++; $display("FAIL b2b_rd_during_wr: got %b want 0", rd); end
    @(negedge clk);
    n_cmp++; if (rd !== 1'b1) begin n_bad++; $display("FAIL b2b_rd_after_wr: got %b want 1", rd); end
    in_empty_1 = 1'b1; in_empty_2 = 1'b1;
    n = 0;
    while (!wr && n < 200) begin @(negedge clk); n++; end
    n_cmp++; if (n != L) begin n_bad++; $display("FAIL b2b_latency: got %0d want %0d", n, L); end
    n_cmp++; if (output_1 !== 28'h0000200) begin n_bad++; $display("FAIL b2b_second_out: got %h want 0000200", output_1); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_patterns;
    test_backpressure;
    test_err;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
